// File: rtl/fft_source_reader.sv
// Avalon-ST sink for FFT output frames: per-bin power stream, per-frame peak
// search and framing-error flag.
module fft_source_reader #(
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned IN_W    = 14,
    parameter int unsigned BIN_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    source_valid,
    input  logic                    source_sop,
    input  logic                    source_eop,
    input  logic signed [IN_W-1:0]  source_real,
    input  logic signed [IN_W-1:0]  source_imag,
    output logic                    source_ready,
    input  logic                    hold,
    output logic [2*IN_W-1:0]       power_o,
    output logic [BIN_W-1:0]        power_bin,
    output logic                    power_valid,
    output logic [BIN_W-1:0]        peak_bin,
    output logic [2*IN_W-1:0]       peak_power,
    output logic                    frame_done,
    output logic                    frame_err
);

    localparam int unsigned        PW       = 2 * IN_W;
    localparam logic [BIN_W-1:0]   LAST_BIN = BIN_W'(FFT_LEN - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               acc_c;
    logic               proc_c;
    logic               first_c;
    logic               last_c;
    logic [BIN_W-1:0]   bin_c;

    logic signed [PW-1:0] re_ext_c, im_ext_c, re_sq_c, im_sq_c;

    logic [PW-1:0]      s1_re_sq_q, s1_im_sq_q;
    logic [BIN_W-1:0]   s1_bin_q;
    logic               s1_valid_q, s1_first_q, s1_last_q;

    logic [PW-1:0]      power_q;
    logic [BIN_W-1:0]   power_bin_q;
    logic               power_valid_q, s2_first_q, s2_last_q;

    logic [PW-1:0]      run_pow_q;
    logic [BIN_W-1:0]   run_bin_q;
    logic               run_upd_c;

    logic [BIN_W-1:0]   peak_bin_q;
    logic [PW-1:0]      peak_pow_q;
    logic               frame_done_q;

    // REPORT blocks one beat so the next sop cannot land on the reporting cycle.
    assign source_ready = ~hold && (state_q != REPORT);
    assign acc_c        = source_valid && source_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        proc_c  = 1'b0;
        first_c = 1'b0;
        last_c  = 1'b0;
        bin_c   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc_c) begin
                    if (source_sop) begin
                        state_d = COLLECT;
                        cnt_d   = BIN_W'(1);
                        err_d   = 1'b0;
                        proc_c  = 1'b1;
                        first_c = 1'b1;
                        bin_c   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (acc_c) begin
                    proc_c = 1'b1;
                    if (source_sop) begin
                        err_d   = 1'b1;
                        cnt_d   = BIN_W'(1);
                        first_c = 1'b1;
                        bin_c   = '0;
                    end else begin
                        cnt_d = cnt_q + BIN_W'(1);
                        if (source_eop && cnt_q == LAST_BIN) begin
                            state_d = REPORT;
                            last_c  = 1'b1;
                            cnt_d   = '0;
                        end else if (source_eop || cnt_q == LAST_BIN) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign re_ext_c = PW'(source_real);
    assign im_ext_c = PW'(source_imag);
    assign re_sq_c  = re_ext_c * re_ext_c;
    assign im_sq_c  = im_ext_c * im_ext_c;

    // Two-stage power pipeline; first/last tags travel with each bin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_re_sq_q    <= '0;
            s1_im_sq_q    <= '0;
            s1_bin_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            power_q       <= '0;
            power_bin_q   <= '0;
            power_valid_q <= 1'b0;
            s2_first_q    <= 1'b0;
            s2_last_q     <= 1'b0;
        end else begin
            s1_valid_q    <= proc_c;
            s1_first_q    <= proc_c && first_c;
            s1_last_q     <= proc_c && last_c;
            if (proc_c) begin
                s1_re_sq_q <= re_sq_c;
                s1_im_sq_q <= im_sq_c;
                s1_bin_q   <= bin_c;
            end
            power_valid_q <= s1_valid_q;
            s2_first_q    <= s1_valid_q && s1_first_q;
            s2_last_q     <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                power_q     <= s1_re_sq_q + s1_im_sq_q;
                power_bin_q <= s1_bin_q;
            end
        end
    end

    // Strict compare: on ties the earlier (lower) bin is kept.
    assign run_upd_c = power_valid_q && (s2_first_q || (power_q > run_pow_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_pow_q    <= '0;
            run_bin_q    <= '0;
            peak_pow_q   <= '0;
            peak_bin_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (run_upd_c) begin
                run_pow_q <= power_q;
                run_bin_q <= power_bin_q;
            end
            frame_done_q <= power_valid_q && s2_last_q;
            if (power_valid_q && s2_last_q) begin
                peak_pow_q <= run_upd_c ? power_q     : run_pow_q;
                peak_bin_q <= run_upd_c ? power_bin_q : run_bin_q;
            end
        end
    end

    assign power_o     = power_q;
    assign power_bin   = power_bin_q;
    assign power_valid = power_valid_q;
    assign peak_bin    = peak_bin_q;
    assign peak_power  = peak_pow_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_fft_source_reader.sv
// Directed bench for fft_source_reader with an 8-bin frame.
module tb_fft_source_reader;

    localparam int unsigned FFT_LEN = 8;
    localparam int unsigned IN_W    = 14;
    localparam int unsigned BIN_W   = 3;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   source_valid, source_sop, source_eop;
    logic signed [IN_W-1:0] source_real, source_imag;
    logic                   source_ready;
    logic                   hold;
    logic [2*IN_W-1:0]      power_o;
    logic [BIN_W-1:0]       power_bin;
    logic                   power_valid;
    logic [BIN_W-1:0]       peak_bin;
    logic [2*IN_W-1:0]      peak_power;
    logic                   frame_done;
    logic                   frame_err;

    fft_source_reader #(.FFT_LEN(FFT_LEN), .IN_W(IN_W), .BIN_W(BIN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_real(source_real), .source_imag(source_imag),
        .source_ready(source_ready), .hold(hold),
        .power_o(power_o), .power_bin(power_bin), .power_valid(power_valid),
        .peak_bin(peak_bin), .peak_power(peak_power),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int          pv_bin_q[$];
    int unsigned pv_pow_q[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    always @(negedge clk) begin
        if (power_valid) begin
            pv_bin_q.push_back(int'(power_bin));
            pv_pow_q.push_back(int'(power_o));
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int timeouts = 0;
    int ready_bad = 0;
    int last_acc_cyc = 0;
    bit hold_en = 1'b0;

    int re_v[16], im_v[16];
    bit sop_v[16], eop_v[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One beat, held until accepted (bounded).
    task automatic beat(input int re, input int im, input bit sop, input bit eop);
        bit acc;
        int n;
        source_real  = IN_W'(re);
        source_imag  = IN_W'(im);
        source_sop   = sop;
        source_eop   = eop;
        source_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            if (hold_en) hold = ~hold;
            #1;
            if (hold_en && (source_ready !== ~hold)) ready_bad++;
            acc = source_valid && source_ready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) timeouts++;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < 16; i++) begin
            re_v[i] = 1; im_v[i] = 1; sop_v[i] = 1'b0; eop_v[i] = 1'b0;
        end
        sop_v[0]   = 1'b1;
        eop_v[n-1] = 1'b1;
    endtask

    task automatic run_beats(input int n);
        for (int i = 0; i < n; i++) beat(re_v[i], im_v[i], sop_v[i], eop_v[i]);
    endtask

    // Checks a completed frame: last 8 power beats are bins 0..7 in order.
    task automatic check_frame(input string tag, input int st, input int fd0, input int n_pv,
                               input int exp_bin, input int exp_pow, input bit exp_err);
        bit ok;
        ok = (pv_bin_q.size() == st + n_pv);
        for (int i = 0; i < 8 && ok; i++)
            if (pv_bin_q[st + n_pv - 8 + i] != i) ok = 1'b0;
        check({tag, "_pv_count"}, 64'(pv_bin_q.size() - st), 64'(n_pv));
        check({tag, "_bin_order"}, 64'(ok), 64'(1));
        check({tag, "_frame_done"}, 64'(fd_cnt - fd0), 64'(1));
        check({tag, "_done_latency"}, 64'(fd_cyc - last_acc_cyc), 64'(3));
        check({tag, "_peak_bin"}, 64'(peak_bin), 64'(exp_bin));
        check({tag, "_peak_power"}, 64'(peak_power), 64'(exp_pow));
        check({tag, "_frame_err"}, 64'(frame_err), 64'(exp_err));
    endtask

    int st, fd0;

    initial begin
        reset_n = 1'b0; hold = 1'b0;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        source_real = '0; source_imag = '0;
        tick(3);
        check("rst_ready", 64'(source_ready), 64'(1));
        check("rst_power_valid", 64'(power_valid), 64'(0));
        check("rst_power", 64'(power_o), 64'(0));
        check("rst_peak_bin", 64'(peak_bin), 64'(0));
        check("rst_peak_power", 64'(peak_power), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        reset_n = 1'b1;
        tick(2);

        // Test 1: bin 3 = (100,-200) -> 10000 + 40000.
        fill(8); re_v[3] = 100; im_v[3] = -200;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        run_beats(8); tick(6);
        check_frame("t1", st, fd0, 8, 3, 50000, 1'b0);
        check("t1_bin0_power", 64'(pv_pow_q[st]), 64'(2));
        check("t1_bin3_power", 64'(pv_pow_q[st+3]), 64'(50000));

        // Test 2: equal maxima at bins 2 and 5, 2*8192^2 = 2^27.
        fill(8);
        re_v[2] = -8192; im_v[2] = -8192; re_v[5] = -8192; im_v[5] = -8192;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        run_beats(8); tick(6);
        check_frame("t2", st, fd0, 8, 2, 134217728, 1'b0);
        check("t2_bin5_power", 64'(pv_pow_q[st+5]), 64'(134217728));

        // Test 3: hold toggling every cycle, same frame as test 1.
        fill(8); re_v[3] = 100; im_v[3] = -200;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        hold_en = 1'b1;
        run_beats(8);
        hold_en = 1'b0; hold = 1'b0;
        tick(6);
        check_frame("t3", st, fd0, 8, 3, 50000, 1'b0);
        check("t3_ready_follows_hold", 64'(ready_bad), 64'(0));

        // Test 4: eop on bin 5 -> error, peak kept; then a clean frame.
        fill(6);
        fd0 = fd_cnt;
        run_beats(6); tick(6);
        check("t4_err_set", 64'(frame_err), 64'(1));
        check("t4_no_done", 64'(fd_cnt - fd0), 64'(0));
        check("t4_peak_bin_kept", 64'(peak_bin), 64'(3));
        check("t4_peak_power_kept", 64'(peak_power), 64'(50000));
        fill(8); re_v[6] = 300; im_v[6] = 0;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        run_beats(8); tick(6);
        check_frame("t4b", st, fd0, 8, 6, 90000, 1'b0);

        // Test 5: sop again at bin 4; restarted frame peak at its bin 2.
        fill(12); re_v[1] = 1000; im_v[1] = 0;
        sop_v[4] = 1'b1; re_v[6] = 0; im_v[6] = -500;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        run_beats(12); tick(6);
        check_frame("t5", st, fd0, 12, 2, 250000, 1'b1);

        // Test 6: reset mid-frame, then beats without sop, then a clean frame.
        fill(8);
        run_beats(4);
        reset_n = 1'b0;
        tick(2);
        check("t6_rst_peak_bin", 64'(peak_bin), 64'(0));
        check("t6_rst_peak_power", 64'(peak_power), 64'(0));
        check("t6_rst_power_valid", 64'(power_valid), 64'(0));
        reset_n = 1'b1;
        tick(2);
        st = pv_bin_q.size(); fd0 = fd_cnt;
        for (int i = 1; i < 4; i++) beat(1, 1, 1'b0, 1'b0);
        tick(5);
        check("t6_dropped_pv", 64'(pv_bin_q.size() - st), 64'(0));
        check("t6_err_set", 64'(frame_err), 64'(1));
        check("t6_no_done", 64'(fd_cnt - fd0), 64'(0));
        fill(8); re_v[3] = 100; im_v[3] = -200;
        st = pv_bin_q.size(); fd0 = fd_cnt;
        run_beats(8); tick(6);
        check_frame("t6b", st, fd0, 8, 3, 50000, 1'b0);

        check("no_timeouts", 64'(timeouts), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
